mem_copy_engine: RTL
====================

// Module: mem_copy_engine
// PURPOSE
//  Initiator side of the dataMemory port: block-copies LENGTH 64-bit words from src_base to dst_base
//  through the single address/write port, then requests an image save and waits for done_saving.
//  Sits between the control FSM and the data memory; the memory reads combinationally and writes
//  whenever write-enable is high, so every memory-side output here is registered and glitch-free.
// PARAMETERS
//  ADDR_W        16     memory address width
//  DATA_W        64     memory word width
//  MEM_DEPTH     15451  number of valid words (legal addresses 0..MEM_DEPTH-1)
//  SAVE_TIMEOUT  1024   cycles to wait for mem_done_saving before flagging error
// PORTS
//  clk              in   1       clock, all state on rising edge
//  rst              in   1       asynchronous, active-high reset
//  start            in   1       1-cycle request; sampled only in IDLE
//  src_base         in   ADDR_W  first source word address (latched on start)
//  dst_base         in   ADDR_W  first destination word address (latched on start)
//  length           in   ADDR_W  number of words to copy (latched on start)
//  busy             out  1       high from the cycle after start acceptance until done/error
//  done             out  1       1-cycle pulse: copy and save finished
//  error            out  1       1-cycle pulse: range violation or save timeout
//  mem_address      out  ADDR_W  memory address (registered)
//  mem_write_data   out  DATA_W  memory write data (registered)
//  mem_write_enable out  1       memory write strobe (registered, high 1 cycle per word)
//  mem_read_data    in   DATA_W  memory read data, combinational from mem_address
//  mem_save         out  1       save request to memory (registered level)
//  mem_done_saving  in   1       save-complete from memory; sticky high once set
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, index/timer 0. Async reset mid-copy drops mem_write_enable
//   and mem_save immediately; a partial copy is abandoned, no done/error pulse.
//  States: IDLE, CHECK, READ, WRITE, SAVE_WAIT, FINISH.
//  IDLE: on start latch src/dst/length, idx=0 -> CHECK. start while busy is ignored.
//  CHECK (1 cycle): sums computed at ADDR_W+1 bits, no wrap. If src_base+length > MEM_DEPTH or
//   dst_base+length > MEM_DEPTH -> pulse error, -> IDLE, no memory access. length==0 -> FINISH
//   (no writes, no save). Else drive mem_address=src_base -> READ.
//  READ: capture mem_read_data into mem_write_data; drive mem_address=dst_base+idx,
//   mem_write_enable=1 -> WRITE.
//  WRITE: mem_write_enable=0. If idx==length-1: mem_save=1, timer=0 -> SAVE_WAIT;
//   else idx++, mem_address=src_base+idx+1 -> READ.
//  Throughput: exactly 2 cycles per word; write i is visible to memory one cycle after read i.
//  Copy order is ascending; overlapping ranges with dst_base>src_base get forward-copy semantics
//   (source words overwritten before read are re-copied); caller's responsibility.
//  SAVE_WAIT: mem_save held high. Because mem_done_saving is sticky, it is only accepted when
//   timer>=1 (at least one cycle after mem_save rose). Accept -> mem_save=0 -> FINISH.
//   timer reaches SAVE_TIMEOUT first -> mem_save=0, pulse error, -> IDLE.
//  FINISH: pulse done, busy=0 next cycle, -> IDLE.
//  busy: 1 in CHECK..FINISH inclusive; 0 in IDLE. done and error never high together.
//  mem_address holds last value when idle; mem_write_enable is 0 in every state except WRITE.
// TESTING
//  1. mem[10..13]=A,B,C,D; start src=10 dst=100 len=4 -> 4 single-cycle writes to 100..103
//     carrying A..D, 2 cycles apart; mem_save rises after last write; done_saving at +3 -> done pulse.
//  2. len=0 -> done 2 cycles after start; mem_write_enable and mem_save never assert.
//  3. src=15450 len=2 -> error pulse in CHECK; no write, no save; busy drops next cycle.
//  4. dst=15449 len=2 (last legal block) -> writes to 15449,15450 succeed, done pulse.
//  5. mem_done_saving tied 0 -> error exactly SAVE_TIMEOUT cycles after mem_save rises; mem_save falls.
//  6. assert rst during third word's WRITE -> mem_write_enable 0 asynchronously; restart len=1 works.

Source files
------------

// File: rtl/mem_copy_engine_if.sv
// Control-side request/status signals and the single data-memory port of mem_copy_engine.
// The engine uses the master modport; the control FSM and memory together use slave.
interface mem_copy_engine_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64
);
    logic              start;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic [ADDR_W-1:0] length;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_enable;
    logic [DATA_W-1:0] mem_read_data;
    logic              mem_save;
    logic              mem_done_saving;

    modport master (
        input  start, src_base, dst_base, length, mem_read_data, mem_done_saving,
        output busy, done, error, mem_address, mem_write_data, mem_write_enable, mem_save
    );

    modport slave (
        output start, src_base, dst_base, length, mem_read_data, mem_done_saving,
        input  busy, done, error, mem_address, mem_write_data, mem_write_enable, mem_save
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Block-copies length words from src_base to dst_base over one memory port (2 cycles per word),
// then requests an image save and waits for mem_done_saving. All memory-side outputs are registered.
module mem_copy_engine #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 64,
    parameter int MEM_DEPTH    = 15451,
    parameter int SAVE_TIMEOUT = 1024
) (
    input logic               clk,
    input logic               rst,
    mem_copy_engine_if.master bus
);
    localparam int TIMER_W = $clog2(SAVE_TIMEOUT + 1);
    localparam logic [ADDR_W:0]    DEPTH_C   = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [TIMER_W-1:0] TIMEOUT_C = TIMER_W'(SAVE_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        READ,
        WRITE,
        SAVE_WAIT,
        FINISH
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   src_q, src_n;
    logic [ADDR_W-1:0]   dst_q, dst_n;
    logic [ADDR_W-1:0]   len_q, len_n;
    logic [ADDR_W-1:0]   idx_q, idx_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic [DATA_W-1:0]   wdata_q, wdata_n;
    logic                we_q, we_n;
    logic                save_q, save_n;
    logic [TIMER_W-1:0]  timer_q, timer_n;

    logic [ADDR_W:0]     src_end;
    logic [ADDR_W:0]     dst_end;
    logic                range_bad;
    logic                save_accept;
    logic                save_timeout;

    // End addresses carry one extra bit so a block running past the top can never wrap back into range.
    assign src_end   = {1'b0, src_q} + {1'b0, len_q};
    assign dst_end   = {1'b0, dst_q} + {1'b0, len_q};
    assign range_bad = (src_end > DEPTH_C) || (dst_end > DEPTH_C);

    // done_saving is sticky, so a level left over from an earlier save must not count in the first cycle.
    assign save_accept  = bus.mem_done_saving && (timer_q != '0);
    assign save_timeout = (timer_q == TIMEOUT_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            save_q  <= 1'b0;
            timer_q <= '0;
        end else begin
            state   <= state_n;
            src_q   <= src_n;
            dst_q   <= dst_n;
            len_q   <= len_n;
            idx_q   <= idx_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            we_q    <= we_n;
            save_q  <= save_n;
            timer_q <= timer_n;
        end
    end

    always_comb begin
        state_n = state;
        src_n   = src_q;
        dst_n   = dst_q;
        len_n   = len_q;
        idx_n   = idx_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        we_n    = 1'b0;
        save_n  = save_q;
        timer_n = timer_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    src_n   = bus.src_base;
                    dst_n   = bus.dst_base;
                    len_n   = bus.length;
                    idx_n   = '0;
                    state_n = CHECK;
                end
            end
            CHECK: begin
                if (range_bad) begin
                    state_n = IDLE;
                end else if (len_q == '0) begin
                    state_n = FINISH;
                end else begin
                    addr_n  = src_q;
                    state_n = READ;
                end
            end
            READ: begin
                wdata_n = bus.mem_read_data;
                addr_n  = dst_q + idx_q;
                we_n    = 1'b1;
                state_n = WRITE;
            end
            WRITE: begin
                if (idx_q == len_q - ADDR_W'(1)) begin
                    save_n  = 1'b1;
                    timer_n = '0;
                    state_n = SAVE_WAIT;
                end else begin
                    idx_n   = idx_q + ADDR_W'(1);
                    addr_n  = src_q + idx_q + ADDR_W'(1);
                    state_n = READ;
                end
            end
            SAVE_WAIT: begin
                timer_n = timer_q + TIMER_W'(1);
                if (save_accept) begin
                    save_n  = 1'b0;
                    state_n = FINISH;
                end else if (save_timeout) begin
                    save_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Status flags are decoded from registered state so done/error line up with the last busy cycle.
    assign bus.busy  = (state != IDLE);
    assign bus.done  = (state == FINISH);
    assign bus.error = ((state == CHECK) && range_bad) ||
                       ((state == SAVE_WAIT) && save_timeout && !save_accept);

    assign bus.mem_address      = addr_q;
    assign bus.mem_write_data   = wdata_q;
    assign bus.mem_write_enable = we_q;
    assign bus.mem_save         = save_q;
endmodule
